// File: rtl/count_history_display_if.sv
// rtl/count_history_display_if.sv - counter input and seven-segment display signals
interface count_history_display_if;
    logic [3:0] count_in;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [3:0] an_o;
    logic       new_val_o;

    modport master (
        input  count_in,
        output seg_o,
        output dp_o,
        output an_o,
        output new_val_o
    );

    modport slave (
        output count_in,
        input  seg_o,
        input  dp_o,
        input  an_o,
        input  new_val_o
    );
endinterface

// File: rtl/count_history_display.sv
// rtl/count_history_display.sv - 4-entry distinct-value history of count_in scanned onto a 4-digit display
// Optional decimal-point blink on the newest digit: DISP_DP_BLINK_EN
module count_history_display #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    count_history_display_if.master disp
);
    logic [3:0]       sync1_q, sync2_q, stab_q;
    logic [2:0]       fill_q;
    logic [3:0][3:0]  h_q;
    logic [3:0]       v_q;
    logic [15:0]      pcnt_q, pcnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q;
    logic [3:0]       an_q;
    logic             nv_q;
    logic             accept;
    logic             last_pcnt;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    // fill_q[2] marks that stab_q holds a real sample, so the zeroed reset
    // contents of the synchronizer are never taken as a counter value.
    assign accept    = fill_q[2] && (sync2_q == stab_q) && (!v_q[0] || (stab_q != h_q[0]));
    assign last_pcnt = (pcnt_q == 16'(SCAN_DIV - 1));
    assign pcnt_d    = last_pcnt ? 16'd0 : pcnt_q + 16'd1;
    assign idx_d     = last_pcnt ? idx_q + 2'd1 : idx_q;

    // Display registers follow idx_d so an_o and seg_o switch together;
    // seg_o reads the pre-shift history on an accept edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            stab_q  <= '0;
            fill_q  <= '0;
            h_q     <= '0;
            v_q     <= '0;
            pcnt_q  <= '0;
            idx_q   <= '0;
            seg_q   <= '0;
            an_q    <= 4'b0001;
            nv_q    <= 1'b0;
        end else begin
            sync1_q <= disp.count_in;
            sync2_q <= sync1_q;
            stab_q  <= sync2_q;
            fill_q  <= {fill_q[1:0], 1'b1};
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            an_q    <= 4'b0001 << idx_d;
            seg_q   <= v_q[idx_d] ? hex_glyph(h_q[idx_d]) : 7'h00;
            nv_q    <= accept;
            if (accept) begin
                h_q <= {h_q[2:0], stab_q};
                v_q <= {v_q[2:0], 1'b1};
            end
        end
    end

`ifdef DISP_DP_BLINK_EN
    logic [7:0] fcnt_q, fcnt_d;
    logic       blink_q, blink_d;
    logic       dp_q;

    always_comb begin
        fcnt_d  = fcnt_q;
        blink_d = blink_q;
        if (accept) begin
            fcnt_d  = 8'd0;
            blink_d = 1'b1;
        end else if (last_pcnt && (idx_q == 2'd3)) begin
            if (fcnt_q == 8'(BLINK_FRAMES - 1)) begin
                fcnt_d  = 8'd0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            blink_q <= 1'b0;
            dp_q    <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            blink_q <= blink_d;
            dp_q    <= blink_d & (idx_d == 2'd0) & v_q[0];
        end
    end

    assign disp.dp_o = dp_q;
`else
    // Constant 0 over the legal BLINK_FRAMES range; blink logic is not built.
    assign disp.dp_o = (BLINK_FRAMES == 0);
`endif

    assign disp.seg_o     = seg_q;
    assign disp.an_o      = an_q;
    assign disp.new_val_o = nv_q;
endmodule

// File: tb/tb_count_history_display.sv
// tb/tb_count_history_display.sv - randomized and directed bench for count_history_display
module tb_count_history_display;
    localparam int SD = 4;
    localparam int BF = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    count_history_display_if dif();

    count_history_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .disp   (dif)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int pulses = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference: samples since reset, history newest-first, edge count since reset.
    int         sq[$];
    int         hist[$];
    int         t      = 0;
    bit         blink  = 1'b0;
    int         frames = 0;
    logic [6:0] seg_e  = 7'h00;
    logic [3:0] an_e   = 4'b0001;
    logic       dp_e   = 1'b0;
    logic       nv_e   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int  n;
        int  idx_new;
        bit  acc;
        if (!rst_n) begin
            sq.delete();
            hist.delete();
            t      = 0;
            blink  = 1'b0;
            frames = 0;
            seg_e  = 7'h00;
            an_e   = 4'b0001;
            dp_e   = 1'b0;
            nv_e   = 1'b0;
        end else begin
            t++;
            idx_new = (t / SD) % 4;
            sq.push_back(int'(dif.count_in));
            if (sq.size() > 4) void'(sq.pop_front());
            n   = sq.size();
            acc = (n >= 4) && (sq[n-3] == sq[n-4]) && (hist.size() == 0 || hist[0] != sq[n-4]);
            seg_e = (idx_new < hist.size()) ? glyph[hist[idx_new]] : 7'h00;
            an_e  = 4'(1 << idx_new);
`ifdef DISP_DP_BLINK_EN
            if (acc) begin
                blink  = 1'b1;
                frames = 0;
            end else if (t % (4 * SD) == 0) begin
                frames++;
                if (frames == BF) begin
                    blink  = ~blink;
                    frames = 0;
                end
            end
            dp_e = blink && (idx_new == 0) && (hist.size() > 0);
`else
            dp_e = 1'b0;
`endif
            if (acc) begin
                hist.push_front(sq[n-4]);
                if (hist.size() > 4) void'(hist.pop_back());
            end
            nv_e = acc;
        end
    end

    always @(negedge clk) begin
        chk("seg", int'(dif.seg_o), int'(seg_e));
        chk("an", int'(dif.an_o), int'(an_e));
        chk("dp", int'(dif.dp_o), int'(dp_e));
        chk("new_val", int'(dif.new_val_o), int'(nv_e));
        pulses += int'(dif.new_val_o);
    end

    task automatic hold(input logic [3:0] v, input int c);
        @(negedge clk);
        dif.count_in = v;
        repeat (c - 1) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] a);
        int n = 0;
        while (dif.an_o !== a && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (dif.an_o !== a) begin
            total++;
            bad++;
            $display("FAIL wait_an: got %0h want %0h", dif.an_o, a);
        end
    endtask

    initial begin
        int p0;
        dif.count_in = 4'd3;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_seg", int'(dif.seg_o), 'h00);
        chk("rst_an", int'(dif.an_o), 'b0001);
        chk("rst_dp", int'(dif.dp_o), 0);
        chk("rst_nv", int'(dif.new_val_o), 0);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (20) @(negedge clk);
        chk("rst_pulses", pulses - p0, 1);
        wait_an(4'b0001);
        chk("h0_is_3", int'(dif.seg_o), 'h4F);

        p0 = pulses;
        hold(4'd1, 20);
        hold(4'd2, 20);
        hold(4'd3, 20);
        hold(4'd4, 20);
        chk("shift_pulses", pulses - p0, 4);
        wait_an(4'b0001);
        chk("frame_d0", int'(dif.seg_o), 'h66);
        repeat (SD) @(negedge clk);
        chk("frame_an1", int'(dif.an_o), 'b0010);
        chk("frame_d1", int'(dif.seg_o), 'h4F);
        repeat (SD) @(negedge clk);
        chk("frame_an2", int'(dif.an_o), 'b0100);
        chk("frame_d2", int'(dif.seg_o), 'h5B);
        repeat (SD) @(negedge clk);
        chk("frame_an3", int'(dif.an_o), 'b1000);
        chk("frame_d3", int'(dif.seg_o), 'h06);

        p0 = pulses;
        hold(4'd5, 1);
        hold(4'd4, 10);
        chk("glitch_pulses", pulses - p0, 0);
        wait_an(4'b0001);
        chk("glitch_d0", int'(dif.seg_o), 'h66);
        p0 = pulses;
        hold(4'd5, 10);
        chk("steady5_pulses", pulses - p0, 1);

        hold(4'hE, 20);
        p0 = pulses;
        hold(4'hF, 20);
        hold(4'h0, 20);
        chk("wrap_pulses", pulses - p0, 2);
        wait_an(4'b0001);
        chk("wrap_d0", int'(dif.seg_o), 'h3F);
        repeat (SD) @(negedge clk);
        chk("wrap_d1", int'(dif.seg_o), 'h71);
        repeat (80) @(negedge clk);

        for (int i = 0; i < 300; i++)
            hold(4'($urandom_range(15, 0)), int'($urandom_range(12, 1)));
        repeat (40) @(negedge clk);

        wait_an(4'b0100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", int'(dif.seg_o), 'h00);
        chk("arst_an", int'(dif.an_o), 'b0001);
        chk("arst_dp", int'(dif.dp_o), 0);
        chk("arst_nv", int'(dif.new_val_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_blank", int'(dif.seg_o), 'h00);
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/count_history_display.md
# count_history_display

Downstream consumer of the 4-bit up-counter in `top`. Samples the free-running count into the `clk_in` domain and keeps a 4-entry history of the last distinct values. Scans the history onto a multiplexed 4-digit seven-segment display, newest value on digit 0. It is the display stage that turns `counter_up` into something visible on the board.

## Interface
- `SCAN_DIV`, default 1000: `clk_in` cycles each digit is enabled; legal range 2..65535.
- `BLINK_FRAMES`, default 64: complete 4-digit scan frames per decimal-point toggle; legal range 1..255; used only with `DISP_DP_BLINK_EN`.
- `clk_in`  in  1: system clock; all logic on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `count_in`  in  4: counter value; may change asynchronously to `clk_in`.
- `seg_o`  out  7: segments, active-high; bit0=a … bit6=g.
- `dp_o`  out  1: decimal point, active-high.
- `an_o`  out  4: digit enable, one-hot, active-high; bit0 = newest digit.
- `new_val_o`  out  1: one-cycle pulse when a new distinct value enters the history.

## Operation
- **Input synchronizer:** `count_in` → `sync1` → `sync2`, plus stability register `stab` ← `sync2`.
  - A value is stable when `sync2 == stab`.
- **Accept rule:** on an edge where `sync2 == stab` and (`!v0` or `stab != h0`):
  - shift `h3←h2`, `h2←h1`, `h1←h0`, `h0←stab`;
  - shift valid bits `v3..v0` the same way, with `v0←1`;
  - register `new_val_o=1` for that one cycle.
- **Repeated value:** an equal stable value causes no shift and no pulse.
- **Scan:**
  - Prescaler `pcnt` counts 0..SCAN_DIV-1.
  - At terminal count: `pcnt←0` and digit index `idx` advances 0→1→2→3→0.
  - `an_o` is registered as `1<<idx`.
- **Segments:**
  - `seg_o` is registered as the hex decode of `h[idx]` when `v[idx]=1`, else 7'h00 (blank).
  - Decode examples: 0→7'h3F, 1→7'h06, 8→7'h7F, A→7'h77, F→7'h71; all 16 codes use the standard hex glyphs.
- **Reset values:**
  - outputs: `seg_o`=7'h00, `dp_o`=0, `an_o`=4'b0001, `new_val_o`=0;
  - internal: `h0..h3`=0, `v`=4'b0000, `idx`=0, `pcnt`=0, sync registers=0.
- **Reset mid-operation:** all state returns to the reset values immediately; the history is lost and the display is blank.

## Timing
- Let edge k be the first rising edge at which `count_in` holds a new value.
  - `sync1` new at k, `sync2` at k+1, `stab` at k+2.
  - Accept, `h0` update and `new_val_o` high all happen at edge k+3; `new_val_o` is low again at k+4.
- **Glitch filter:** a value that occupies `sync2` for fewer than 2 consecutive edges is never accepted.
- **Display latency:** `seg_o` reflects the new `h0` from edge k+4 if `idx=0`. Otherwise it appears when `idx` next reaches 0.
- **Digit switch:** `an_o` and `seg_o` change on the same edge. Each digit stays enabled exactly `SCAN_DIV` cycles, so one frame is 4·`SCAN_DIV` cycles.
- **Simultaneous events:** an accept on the same edge as a digit switch is allowed. `seg_o` decodes the pre-shift history on that edge and the post-shift history from the next edge.
- **Wrap-around:** counter wrap F→0 is a distinct value and shifts normally. After 4 accepts all `v`=1 and the oldest entry drops off.

## Configuration
- **`DISP_DP_BLINK_EN` defined:**
  - A frame counter counts completed frames (`idx` 3→0 transitions).
  - Every `BLINK_FRAMES` frames, toggle bit `blink` flips.
  - `dp_o` = `blink` & (`idx`==0) & `v0`, registered alongside `seg_o`.
  - An accept forces `blink←1` and clears the frame counter.
  - Reset: `blink`=0, frame counter=0.
- **`DISP_DP_BLINK_EN` not defined:** `dp_o` is tied to 0 and the frame counter and `blink` are not built.

## Test plan
Bench uses `SCAN_DIV`=4 and `BLINK_FRAMES`=2.
- **Reset:** hold `rst_n`=0 for 5 cycles with `count_in`=3 → `seg_o`=7'h00, `an_o`=4'b0001, `dp_o`=0, `new_val_o`=0. Release → exactly one `new_val_o` pulse, 3 cycles after release; `h0`=3.
- **History shift:** step `count_in` through 1,2,3,4, holding each 20 cycles → 4 pulses. During a full frame, `an_o`/`seg_o` pairs are 0001/7'h66 (4), 0010/7'h4F (3), 0100/7'h5B (2), 1000/7'h06 (1).
- **Glitch rejection:** drive 5 for 1 cycle, then back to 4 → no `new_val_o`, history unchanged. Then hold 5 steady → pulse at edge k+3.
- **Wrap-around:** from a history holding E, apply F then 0 → 2 pulses; digit 0 shows 7'h3F and digit 1 shows 7'h71.
- **Blink (macro defined):** after an accept, `dp_o` is high in `idx`=0 slots for frames 1–2, low for frames 3–4, then high again. With the macro undefined, `dp_o` stays 0 throughout.
- **Async reset mid-scan:** pull `rst_n` low between clock edges while `idx`=2 → outputs take the reset values immediately, and the history is blank after release until the next accept.
